// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the RISC instruction sequencer.
//   - opcode constants as decoded from the instruction register
//   - sequencer state encoding
//   - is_alu_read(): opcodes that read a memory operand into the accumulator
package risc_pkg;

  localparam logic [2:0] HALT  = 3'd0;
  localparam logic [2:0] JRZ   = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] AND   = 3'd3;
  localparam logic [2:0] XOR   = 3'd4;
  localparam logic [2:0] LOAD  = 3'd5;
  localparam logic [2:0] STORE = 3'd6;
  localparam logic [2:0] JUMP  = 3'd7;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    OPRD,
    ACC,
    OPWR,
    JMP,
    SKIP,
    HALTED
  } state_t;

  // An unknown opcode falls to the default branch and is not an ALU read.
  function automatic logic is_alu_read(input logic [2:0] op);
    case (op)
      ADD, AND, XOR, LOAD: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/risc_wait_timer.sv
// risc_wait_timer: counts wait cycles of one memory access.
//   clk     in  clock (state updates on falling edge)
//   rst     in  synchronous active-high reset
//   clear   in  restart the count
//   count   in  this cycle is a wait cycle
//   limit   in  number of wait cycles allowed
//   expired out this wait cycle is the one that reaches the limit
module risc_wait_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         count,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(negedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Looks one cycle ahead so the state machine can leave on the limit cycle.
  assign expired = count && (cnt == limit - 1'b1);

endmodule

// File: rtl/risc_ctrl_seq.sv
// risc_ctrl_seq: variable-length instruction sequencer for the RISC CPU.
//   clk_ctrl       in  control clock, state advances on the falling edge
//   rst            in  synchronous active-high reset
//   enable         in  run enable, low returns to IDLE and clears bus_err
//   resume         in  pulse that leaves HALTED
//   mem_ready      in  memory completes the current access this cycle
//   opcode         in  instruction opcode (sampled in DECODE)
//   alu_zero_flag  in  accumulator-zero flag (sampled in DECODE)
//   halt .. mem_wr out datapath / memory strobes
//   ir_sel         out IR word slot written while load_ir is high
//   instr_done     out pulse on the last cycle of each instruction
//   bus_err        out sticky wait-timeout flag
module risc_ctrl_seq
  import risc_pkg::*;
#(
  parameter int unsigned FETCH_WORDS = 2,
  parameter int unsigned WAIT_LIMIT  = 0,
  parameter int unsigned CNT_W       = (FETCH_WORDS > 1) ? $clog2(FETCH_WORDS) : 1
) (
  input  logic             clk_ctrl,
  input  logic             rst,
  input  logic             enable,
  input  logic             resume,
  input  logic             mem_ready,
  input  logic [2:0]       opcode,
  input  logic             alu_zero_flag,
  output logic             halt,
  output logic             inc_pc,
  output logic             load_pc,
  output logic             load_ir,
  output logic             load_acc,
  output logic             bus_enable,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [CNT_W-1:0] ir_sel,
  output logic             instr_done,
  output logic             bus_err
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FETCH_WORDS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             expired;

  generate
    if (WAIT_LIMIT > 0) begin : g_timer
      localparam int unsigned TW = $clog2(WAIT_LIMIT + 1);
      logic wait_cnt_en;
      logic wait_clr;

      assign wait_cnt_en = !mem_ready &&
                           (state == FETCH || state == OPRD || state == OPWR);
      // A completed access also restarts the count so each fetch word gets
      // its own budget.
      assign wait_clr    = !enable || mem_ready || (state_nx != state);

      risc_wait_timer #(
        .W(TW)
      ) u_timer (
        .clk     (clk_ctrl),
        .rst     (rst),
        .clear   (wait_clr),
        .count   (wait_cnt_en),
        .limit   (TW'(WAIT_LIMIT)),
        .expired (expired)
      );
    end else begin : g_no_timer
      assign expired = 1'b0;
    end
  endgenerate

  always_ff @(negedge clk_ctrl) begin
    if (rst || !enable) begin
      state   <= IDLE;
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (expired) begin
        bus_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    halt       = 1'b0;
    inc_pc     = 1'b0;
    load_pc    = 1'b0;
    load_ir    = 1'b0;
    load_acc   = 1'b0;
    bus_enable = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_sel     = '0;
    instr_done = 1'b0;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (enable) state_nx = FETCH;
      end
      FETCH: begin
        mem_rd  = 1'b1;
        ir_sel  = cnt;
        inc_pc  = mem_ready;
        // expired implies mem_ready low: the aborted word is not loaded.
        load_ir = !expired;
        if (mem_ready) begin
          if (cnt == LAST_WORD) begin
            state_nx = DECODE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else if (expired) begin
          state_nx = HALTED;
        end
      end
      DECODE: begin
        case (opcode)
          HALT:  state_nx = HALTED;
          JRZ: begin
            if (alu_zero_flag) begin
              state_nx = SKIP;
            end else begin
              instr_done = 1'b1;
              state_nx   = FETCH;
            end
          end
          STORE: state_nx = OPWR;
          JUMP:  state_nx = JMP;
          default: state_nx = is_alu_read(opcode) ? OPRD : HALTED;
        endcase
      end
      OPRD: begin
        mem_rd = 1'b1;
        if (mem_ready)    state_nx = ACC;
        else if (expired) state_nx = HALTED;
      end
      ACC: begin
        load_acc   = 1'b1;
        instr_done = 1'b1;
        state_nx   = FETCH;
      end
      OPWR: begin
        bus_enable = 1'b1;
        mem_wr     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_nx   = FETCH;
        end else if (expired) begin
          state_nx = HALTED;
        end
      end
      JMP: begin
        load_pc    = 1'b1;
        instr_done = 1'b1;
        state_nx   = FETCH;
      end
      SKIP: begin
        inc_pc = 1'b1;
        if (cnt == LAST_WORD) begin
          instr_done = 1'b1;
          state_nx   = FETCH;
          cnt_nx     = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HALTED: begin
        halt = 1'b1;
        if (resume && enable) begin
          instr_done = 1'b1;
          state_nx   = FETCH;
          cnt_nx     = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// tb_risc_ctrl_seq: directed bench for risc_ctrl_seq.
// dut_a: FETCH_WORDS=2, WAIT_LIMIT=4. dut_b: FETCH_WORDS=3, WAIT_LIMIT=0.
// Both share the input stimulus; each step checks one of them.
// Observation word: {halt,inc_pc,load_pc,load_ir,load_acc,bus_enable,
//                    mem_rd,mem_wr,instr_done,bus_err,ir_sel[1:0]}
module tb_risc_ctrl_seq;
  import risc_pkg::*;

  localparam logic [11:0] H  = 12'h800;
  localparam logic [11:0] IP = 12'h400;
  localparam logic [11:0] LP = 12'h200;
  localparam logic [11:0] LI = 12'h100;
  localparam logic [11:0] LA = 12'h080;
  localparam logic [11:0] BE = 12'h040;
  localparam logic [11:0] RD = 12'h020;
  localparam logic [11:0] WR = 12'h010;
  localparam logic [11:0] DN = 12'h008;
  localparam logic [11:0] BR = 12'h004;
  localparam logic [11:0] S1 = 12'h001;
  localparam logic [11:0] S2 = 12'h002;
  localparam logic [11:0] F  = RD | LI | IP;

  logic       clk_ctrl;
  logic       rst, enable, resume, mem_ready, alu_zero_flag;
  logic [2:0] opcode;

  logic       halt_a, inc_pc_a, load_pc_a, load_ir_a, load_acc_a;
  logic       bus_enable_a, mem_rd_a, mem_wr_a, instr_done_a, bus_err_a;
  logic [0:0] ir_sel_a;
  logic       halt_b, inc_pc_b, load_pc_b, load_ir_b, load_acc_b;
  logic       bus_enable_b, mem_rd_b, mem_wr_b, instr_done_b, bus_err_b;
  logic [1:0] ir_sel_b;
  logic [11:0] obs_a, obs_b;

  int checks   = 0;
  int failures = 0;
  int inc_b    = 0;
  logic [11:0] exp_q[$];

  risc_ctrl_seq #(
    .FETCH_WORDS(2),
    .WAIT_LIMIT (4)
  ) dut_a (
    .clk_ctrl     (clk_ctrl),
    .rst          (rst),
    .enable       (enable),
    .resume       (resume),
    .mem_ready    (mem_ready),
    .opcode       (opcode),
    .alu_zero_flag(alu_zero_flag),
    .halt         (halt_a),
    .inc_pc       (inc_pc_a),
    .load_pc      (load_pc_a),
    .load_ir      (load_ir_a),
    .load_acc     (load_acc_a),
    .bus_enable   (bus_enable_a),
    .mem_rd       (mem_rd_a),
    .mem_wr       (mem_wr_a),
    .ir_sel       (ir_sel_a),
    .instr_done   (instr_done_a),
    .bus_err      (bus_err_a)
  );

  risc_ctrl_seq #(
    .FETCH_WORDS(3),
    .WAIT_LIMIT (0)
  ) dut_b (
    .clk_ctrl     (clk_ctrl),
    .rst          (rst),
    .enable       (enable),
    .resume       (resume),
    .mem_ready    (mem_ready),
    .opcode       (opcode),
    .alu_zero_flag(alu_zero_flag),
    .halt         (halt_b),
    .inc_pc       (inc_pc_b),
    .load_pc      (load_pc_b),
    .load_ir      (load_ir_b),
    .load_acc     (load_acc_b),
    .bus_enable   (bus_enable_b),
    .mem_rd       (mem_rd_b),
    .mem_wr       (mem_wr_b),
    .ir_sel       (ir_sel_b),
    .instr_done   (instr_done_b),
    .bus_err      (bus_err_b)
  );

  assign obs_a = {halt_a, inc_pc_a, load_pc_a, load_ir_a, load_acc_a, bus_enable_a,
                  mem_rd_a, mem_wr_a, instr_done_a, bus_err_a, 1'b0, ir_sel_a};
  assign obs_b = {halt_b, inc_pc_b, load_pc_b, load_ir_b, load_acc_b, bus_enable_b,
                  mem_rd_b, mem_wr_b, instr_done_b, bus_err_b, ir_sel_b};

  initial begin
    clk_ctrl = 1'b0;
    forever #5 clk_ctrl = ~clk_ctrl;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (checks=%0d failures=%0d)", checks, failures);
    $fatal(1);
  end

  // Inputs change on the rising edge; the DUT acts on the falling edge.
  task automatic cyc(input int which, input logic rs, input logic en, input logic res,
                     input logic rdy, input logic [2:0] op, input logic z,
                     input logic [11:0] e, input string tag);
    logic [11:0] o;
    logic [11:0] ex;
    @(posedge clk_ctrl);
    rst           = rs;
    enable        = en;
    resume        = res;
    mem_ready     = rdy;
    opcode        = op;
    alu_zero_flag = z;
    exp_q.push_back(e);
    #1;
    o  = (which == 1) ? obs_b : obs_a;
    ex = exp_q.pop_front();
    checks++;
    assert (o === ex) else begin
      failures++;
      $error("FAIL %s observed=%03h expected=%03h", tag, o, ex);
    end
    if (which == 1 && o[10] === 1'b1) inc_b++;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; resume = 1'b0; mem_ready = 1'b0;
    opcode = HALT; alu_zero_flag = 1'b0;
    repeat (2) @(negedge clk_ctrl);

    // Reset state
    cyc(0, 0, 0, 0, 0, HALT, 0, 12'h000, "reset_a");
    cyc(1, 0, 0, 0, 0, HALT, 0, 12'h000, "reset_b");

    // ADD, zero waits
    cyc(0, 0, 1, 0, 1, ADD, 0, 12'h000, "add_idle");
    cyc(0, 0, 1, 0, 1, ADD, 0, F,       "add_f0");
    cyc(0, 0, 1, 0, 1, ADD, 0, F | S1,  "add_f1");
    cyc(0, 0, 1, 0, 1, ADD, 0, 12'h000, "add_dec");
    cyc(0, 0, 1, 0, 1, ADD, 0, RD,      "add_oprd");
    cyc(0, 0, 1, 0, 1, ADD, 0, LA | DN, "add_acc");

    // STORE with 3 wait cycles
    cyc(0, 0, 1, 0, 1, STORE, 0, F,       "st_f0");
    cyc(0, 0, 1, 0, 1, STORE, 0, F | S1,  "st_f1");
    cyc(0, 0, 1, 0, 1, STORE, 0, 12'h000, "st_dec");
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 0, 0, STORE, 0, BE | WR, "st_wait");
    cyc(0, 0, 1, 0, 1, STORE, 0, BE | WR | DN, "st_done");

    // LOAD operand read times out after 4 wait cycles
    cyc(0, 0, 1, 0, 1, LOAD, 0, F,       "to_f0");
    cyc(0, 0, 1, 0, 1, LOAD, 0, F | S1,  "to_f1");
    cyc(0, 0, 1, 0, 1, LOAD, 0, 12'h000, "to_dec");
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 1, 0, 0, LOAD, 0, RD, "to_oprd");
    cyc(0, 0, 1, 0, 0, LOAD, 0, H | BR,       "to_halted");
    cyc(0, 0, 1, 1, 0, LOAD, 0, H | BR | DN,  "to_resume");
    cyc(0, 0, 1, 0, 1, LOAD, 0, F | BR,       "to_fetch_err");
    cyc(0, 0, 0, 0, 1, LOAD, 0, F | S1 | BR,  "to_en_low");
    cyc(0, 0, 0, 0, 1, LOAD, 0, 12'h000,      "to_cleared");

    // HALT, hold, resume; resume ignored during FETCH
    cyc(0, 0, 1, 0, 1, HALT, 0, 12'h000, "h_idle");
    cyc(0, 0, 1, 0, 1, HALT, 0, F,       "h_f0");
    cyc(0, 0, 1, 0, 1, HALT, 0, F | S1,  "h_f1");
    cyc(0, 0, 1, 0, 1, HALT, 0, 12'h000, "h_dec");
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 1, 0, 1, HALT, 0, H, "h_hold");
    cyc(0, 0, 1, 1, 1, HALT, 0, H | DN,  "h_resume");
    cyc(0, 0, 1, 1, 0, HALT, 0, RD | LI, "h_ign0");
    cyc(0, 0, 1, 0, 0, HALT, 0, RD | LI, "h_ign1");
    cyc(0, 0, 1, 0, 1, HALT, 0, F,       "h_f0b");

    // Unknown opcode decodes as HALT
    cyc(0, 0, 1, 0, 1, 3'bxxx, 0, F | S1,  "x_f1");
    cyc(0, 0, 1, 0, 1, 3'bxxx, 0, 12'h000, "x_dec");
    cyc(0, 0, 1, 0, 1, 3'bxxx, 0, H,       "x_halted");

    // Reset in the middle of a stalled OPWR
    cyc(0, 0, 1, 1, 1, STORE, 0, H | DN,  "r_resume");
    cyc(0, 0, 1, 0, 1, STORE, 0, F,       "r_f0");
    cyc(0, 0, 1, 0, 1, STORE, 0, F | S1,  "r_f1");
    cyc(0, 0, 1, 0, 1, STORE, 0, 12'h000, "r_dec");
    cyc(0, 0, 1, 0, 0, STORE, 0, BE | WR, "r_opwr");
    cyc(0, 1, 1, 0, 0, STORE, 0, BE | WR, "r_opwr_rst");
    cyc(0, 0, 1, 0, 0, STORE, 0, 12'h000, "r_after_rst");
    cyc(0, 0, 1, 0, 0, STORE, 0, RD | LI, "r_fetch0");

    // JRZ not taken, then JUMP
    cyc(0, 0, 1, 0, 1, JRZ, 0, F,        "jnt_f0");
    cyc(0, 0, 1, 0, 1, JRZ, 0, F | S1,   "jnt_f1");
    cyc(0, 0, 1, 0, 1, JRZ, 0, DN,       "jnt_dec");
    cyc(0, 0, 1, 0, 1, JUMP, 0, F,       "jmp_f0");
    cyc(0, 0, 1, 0, 1, JUMP, 0, F | S1,  "jmp_f1");
    cyc(0, 0, 1, 0, 1, JUMP, 0, 12'h000, "jmp_dec");
    cyc(0, 0, 1, 0, 1, JUMP, 0, LP | DN, "jmp_exec");
    cyc(0, 1, 1, 0, 1, JUMP, 0, F,       "jmp_f0_rst");

    // JRZ taken with three fetch words (dut_b)
    cyc(1, 0, 1, 0, 1, JRZ, 1, 12'h000, "b_idle");
    cyc(1, 0, 1, 0, 1, JRZ, 1, F,       "b_f0");
    cyc(1, 0, 1, 0, 1, JRZ, 1, F | S1,  "b_f1");
    cyc(1, 0, 1, 0, 1, JRZ, 1, F | S2,  "b_f2");
    cyc(1, 0, 1, 0, 1, JRZ, 1, 12'h000, "b_dec");
    cyc(1, 0, 1, 0, 1, JRZ, 1, IP,      "b_skip0");
    cyc(1, 0, 1, 0, 1, JRZ, 1, IP,      "b_skip1");
    cyc(1, 0, 1, 0, 1, JRZ, 1, IP | DN, "b_skip2");
    checks++;
    assert (inc_b == 6) else begin
      failures++;
      $error("FAIL b_inc_total observed=%0d expected=6", inc_b);
    end
    cyc(1, 0, 1, 0, 1, JRZ, 1, F, "b_f0_again");

    // No timeout when WAIT_LIMIT is 0
    for (int i = 0; i < 6; i++)
      cyc(1, 0, 1, 0, 0, JRZ, 1, RD | LI | S1, "b_unbounded_wait");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risc_ctrl_seq.md
# risc_ctrl_seq

Parametrised instruction sequencer for the RISC CPU. It replaces the fixed 8-cycle controller with a variable-length state machine, so each instruction takes only the cycles it needs. Memory accesses are stretched by a `mem_ready` handshake with an optional wait timeout. It sits between the instruction register/ALU (inputs `opcode`, `alu_zero_flag`) and the datapath/memory strobes.

## Interface
- `FETCH_WORDS`, default 2: memory words per instruction, legal range 1..4.
- `WAIT_LIMIT`, default 0: maximum cycles one access may wait; 0 means unbounded.
- `CNT_W`, derived as max(1, clog2(FETCH_WORDS)): width of the word counter and `ir_sel`.

Ports:
- `clk_ctrl`  in  1  control clock; all state updates occur on its falling edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the falling edge of `clk_ctrl`.
- `enable`  in  1  run enable; low aborts to IDLE.
- `resume`  in  1  one-cycle pulse that leaves HALTED.
- `mem_ready`  in  1  memory has completed the current rd/wr in this cycle.
- `opcode`  in  3  current instruction opcode from the IR.
- `alu_zero_flag`  in  1  accumulator-zero flag.
- `halt`, `inc_pc`, `load_pc`, `load_ir`, `load_acc`, `bus_enable`, `mem_rd`, `mem_wr`  out  1 each  datapath/memory strobes.
- `ir_sel`  out  CNT_W  IR word slot written while `load_ir` is high.
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction.
- `bus_err`  out  1  sticky wait-timeout flag.

## Operation
- States: IDLE, FETCH, DECODE, OPRD, ACC, OPWR, JMP, SKIP, HALTED.
- All outputs are decoded combinationally from the state and inputs. Any output not listed for a state is 0.
- `rst` forces IDLE, the word counter to 0, the wait counter to 0 and `bus_err` to 0. Every output therefore reads 0 after reset.
- `enable` low forces IDLE on the next edge from any state, including mid-wait. `bus_err` is also cleared. `rst` takes priority over `enable`.
- **IDLE**: leaves to FETCH with word counter 0 when `enable` is high.
- **FETCH**: `mem_rd`=1, `load_ir`=1, `ir_sel`=counter, `inc_pc`=`mem_ready`.
  - If `mem_ready` is high: when counter is FETCH_WORDS-1, go to DECODE with counter reset to 0; otherwise increment the counter.
  - If `mem_ready` is low: hold.
- **DECODE**: one cycle, all outputs 0. Next state by opcode:
  - HALT → HALTED.
  - JRZ with `alu_zero_flag`=1 → SKIP.
  - JRZ with `alu_zero_flag`=0 → FETCH, asserting `instr_done`.
  - ADD/AND/XOR/LOAD → OPRD.
  - STORE → OPWR.
  - JUMP → JMP.
- **OPRD**: `mem_rd`=1. Holds until `mem_ready`, then goes to ACC.
- **ACC**: `load_acc`=1 and `instr_done`=1 → FETCH.
- **OPWR**: `bus_enable`=1 and `mem_wr`=1 for the whole state. On `mem_ready`: `instr_done`=1 → FETCH.
- **JMP**: `load_pc`=1 and `instr_done`=1 → FETCH.
- **SKIP**: `inc_pc`=1 for exactly FETCH_WORDS cycles, counted with the word counter. `instr_done` is asserted on the last of those cycles, then → FETCH.
- **HALTED**: `halt`=1. On `resume` (with `enable` high): `instr_done`=1 → FETCH. `resume` is ignored in every other state.
- **Wait timeout**: a cycle in FETCH, OPRD or OPWR with `mem_ready` low increments the wait counter. The counter clears on every state change. If WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT with `mem_ready` still low:
  - next state is HALTED;
  - `bus_err` is set, and stays set until `rst` or `enable` goes low;
  - the `inc_pc`/`load_*` strobes are not issued for the aborted access.
- **Unknown/X opcode**: treated as HALT.

## Timing
- Zero-wait cycle counts (FETCH_WORDS=2): ADD/AND/XOR/LOAD take 5 cycles, STORE 4, JUMP 4, JRZ not-taken 3, JRZ taken 5, HALT 3 to reach HALTED.
- In general, FETCH_WORDS+1 cycles are spent before execute, plus 1 cycle per wait state.
- `opcode` and `alu_zero_flag` are sampled only in DECODE. They must be stable from the end of FETCH through DECODE.
- `mem_ready` is sampled at the same falling edge that advances the state. Strobes change immediately after that edge.
- `mem_ready` arriving on the same cycle the timeout limit is reached counts as success, not as a timeout.

## Structure
- Package `risc_pkg` holds:
  - opcode constants HALT=0, JRZ=1, ADD=2, AND=3, XOR=4, LOAD=5, STORE=6, JUMP=7;
  - the state encoding;
  - the helper function `is_alu_read(opcode)`.
- One sub-module, `risc_wait_timer`: the wait counter with inputs clear/count/limit and output `expired`. It is omitted by generate when WAIT_LIMIT=0.

## Test plan
- **Reset mid-OPWR** with `mem_ready`=0: `rst` pulse → all outputs 0 on the next edge; after `rst` is released and `enable`=1, FETCH with `ir_sel`=0.
- **ADD with zero waits**, FETCH_WORDS=2: `ir_sel` sequence 0,1; `inc_pc` high for 2 cycles; `load_acc` pulse in cycle 5; `instr_done` in cycle 5.
- **JRZ taken**, FETCH_WORDS=3, `alu_zero_flag`=1: 3 fetch `inc_pc` cycles + 3 SKIP `inc_pc` cycles → 6 increments in total, then FETCH.
- **STORE with 3 wait cycles**: `mem_wr`/`bus_enable` held for 4 cycles; `instr_done` on the cycle `mem_ready`=1.
- **Timeout**, WAIT_LIMIT=4, `mem_ready` stuck at 0 in OPRD: HALTED after 4 cycles with `bus_err`=1 and no `load_acc`; a `resume` pulse → FETCH with `bus_err` still 1; `enable` low clears it.
- **HALT then `resume`**: `halt`=1 held while `resume`=0 for 10 cycles; a `resume` pulse → FETCH on the next cycle; a `resume` pulse during FETCH is ignored.
